// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// controller states and the source-count ceiling.
package int_ctrl_pkg;

  localparam int INT_N_MAX = 8;

  localparam logic [2:0] OFF_MASK = 3'd0;
  localparam logic [2:0] OFF_PEND = 3'd1;
  localparam logic [2:0] OFF_EDGE = 3'd2;
  localparam logic [2:0] OFF_STAT = 3'd3;
  localparam logic [2:0] OFF_EOI  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SVC
  } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set index of cand wins; any flags a candidate.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] cand,
  output logic         any,
  output logic [2:0]   id
);

  always_comb begin
    any = 1'b0;
    id  = 3'd0;
    // Scan downward so the lowest index is the last (winning) assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        any = 1'b1;
        id  = 3'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller: per-source level/edge latching, mask,
// fixed priority, request held to ack, in-service until EOI.
//   state | meaning
//   IDLE  | no request outstanding, waiting for an enabled pending source
//   REQ   | int_req high, int_id follows the current winner
//   SVC   | handler running, new requests stay pending until EOI
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [29:0]  Addr,
  input  logic         WE,
  input  logic [31:0]  Din,
  output logic [31:0]  Dout,
  input  logic [N-1:0] irq_in,
  output logic         int_req,
  output logic [2:0]   int_id,
  input  logic         int_ack
);

  state_t       state_q, state_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] edge_sel_q, edge_sel_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] irq_q;
  logic         int_req_q, int_req_d;
  logic [2:0]   int_id_q, int_id_d;
  logic [2:0]   svc_id_q, svc_id_d;

  logic [2:0]   off;
  logic         wr_mask, wr_pend, wr_edge, wr_eoi;
  logic [N-1:0] cand, ack_clr, w1c, rise;
  logic         any;
  logic [2:0]   win_id;
  logic [2:0]   stat_id;
  logic         unused_ok;

  assign off       = Addr[2:0];
  assign wr_mask   = WE && (off == OFF_MASK);
  assign wr_pend   = WE && (off == OFF_PEND);
  assign wr_edge   = WE && (off == OFF_EDGE);
  assign wr_eoi    = WE && (off == OFF_EOI);
  assign cand      = pend_q & mask_q;
  assign unused_ok = ^{Addr[29:3], Din[31:N]};

  int_prio_enc #(.N(N)) u_prio (
    .cand (cand),
    .any  (any),
    .id   (win_id)
  );

  always_comb begin
    state_d  = state_q;
    int_id_d = int_id_q;
    svc_id_d = svc_id_q;
    ack_clr  = '0;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d  = REQ;
          int_id_d = win_id;
        end
      end
      REQ: begin
        if (!any) begin
          state_d = IDLE;
        end else if (int_ack) begin
          state_d  = SVC;
          svc_id_d = int_id_q;
          ack_clr  = N'(1) << int_id_q;
        end else begin
          int_id_d = win_id;
        end
      end
      SVC: begin
        if (wr_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    int_req_d = (state_d == REQ);

    // Edge bits: a fresh rising edge beats a same-cycle W1C or ack clear.
    w1c        = wr_pend ? Din[N-1:0] : '0;
    rise       = irq_in & ~irq_q;
    pend_d     = (edge_sel_q & ((pend_q & ~(w1c | ack_clr)) | rise))
               | (~edge_sel_q & irq_in);
    mask_d     = wr_mask ? Din[N-1:0] : mask_q;
    edge_sel_d = wr_edge ? Din[N-1:0] : edge_sel_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      edge_sel_q <= '0;
      pend_q     <= '0;
      irq_q      <= '0;
      int_req_q  <= 1'b0;
      int_id_q   <= 3'd0;
      svc_id_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      pend_q     <= pend_d;
      irq_q      <= irq_in;
      int_req_q  <= int_req_d;
      int_id_q   <= int_id_d;
      svc_id_q   <= svc_id_d;
    end
  end

  assign stat_id = (state_q == SVC) ? svc_id_q : int_id_q;

  always_comb begin
    Dout = 32'd0;
    case (off)
      OFF_MASK: Dout = 32'(mask_q);
      OFF_PEND: Dout = 32'(pend_q);
      OFF_EDGE: Dout = 32'(edge_sel_q);
      OFF_STAT: Dout = {28'd0, (state_q == SVC), stat_id};
      default:  Dout = 32'd0;
    endcase
  end

  assign int_req = int_req_q;
  assign int_id  = int_id_q;

endmodule
